// File: rtl/m_uart_tx_fifo.sv
// m_uart_tx_fifo
//   Buffered 8N1 UART transmitter. Characters pushed from the core are queued
//   in a circular FIFO and serialized LSB-first as start(0), 8 data bits,
//   stop(1), each bit held UART_CNT clocks. Back-to-back frames have no gap.
//
// Ports
//   w_clk       in   clock
//   w_rst_n     in   asynchronous reset, active-low
//   w_we        in   push w_din this cycle (dropped when w_full)
//   w_din       in   character to send
//   w_full      out  FIFO holds 2^DEPTH_LOG2 entries
//   w_count     out  FIFO occupancy, excluding the character being shifted
//   w_drained   out  FIFO empty and transmitter idle
//   w_overflow  out  sticky: a push was dropped because the FIFO was full
//   w_uart_tx   out  registered serial line, idles high
module m_uart_tx_fifo #(
  parameter int UART_CNT   = 40,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_we,
  input  logic [7:0]            w_din,
  output logic                  w_full,
  output logic [DEPTH_LOG2:0]   w_count,
  output logic                  w_drained,
  output logic                  w_overflow,
  output logic                  w_uart_tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [DEPTH_LOG2:0]   r_count;
  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic [2:0]            r_bit;
  logic [7:0]            r_shift;
  logic                  r_tx;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_bit_end;
  logic [7:0]            w_rd_data;
  logic [1:0]            w_state_next;
  logic [7:0]            w_shift_next;
  logic [2:0]            w_bit_next;
  logic [7:0]            w_cnt_next;
  logic                  w_tx_next;
  logic [DEPTH_LOG2:0]   w_count_next;

  assign w_full     = (r_count == DEPTH[DEPTH_LOG2:0]);
  assign w_count    = r_count;
  assign w_drained  = (r_count == '0) && (r_state == S_IDLE);
  assign w_overflow = r_overflow;
  assign w_uart_tx  = r_tx;

  // Full is judged on the pre-cycle count, so a pop in the same cycle does
  // not make room for a push.
  assign w_push    = w_we && !w_full;
  assign w_bit_end = (r_cnt == UART_CNT[7:0]);
  assign w_rd_data = r_mem[r_head];

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_shift_next = w_rd_data;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_bit_next   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next start bit when more data waits.
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_shift_next = w_rd_data;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The bit timer restarts on every state entry and at every bit boundary
  // inside DATA; it parks at 1 while idle.
  always_comb begin
    if ((w_state_next != r_state) || w_bit_end || (r_state == S_IDLE)) begin
      w_cnt_next = 8'd1;
    end else begin
      w_cnt_next = r_cnt + 8'd1;
    end
  end

  // Line level is derived from the next state so the registered output
  // changes on the same edge as the state.
  always_comb begin
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_din;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_cnt      <= 8'd1;
      r_bit      <= 3'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_we && w_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_next;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_m_uart_tx_fifo.sv
// tb_m_uart_tx_fifo
//   Randomized bench for m_uart_tx_fifo (UART_CNT=4, DEPTH_LOG2=2). A queue
//   based model tracks FIFO contents and the position inside the current
//   frame; every cycle the line and status outputs are compared against it,
//   and a sampling receiver rebuilds the transmitted bytes.
module tb_m_uart_tx_fifo;

  localparam int U  = 4;
  localparam int DL = 2;
  localparam int D  = 1 << DL;
  localparam int FRAME = 10 * U;

  logic          w_clk = 1'b0;
  logic          w_rst_n = 1'b0;
  logic          w_we = 1'b0;
  logic [7:0]    w_din = 8'd0;
  logic          w_full;
  logic [DL:0]   w_count;
  logic          w_drained;
  logic          w_overflow;
  logic          w_uart_tx;

  m_uart_tx_fifo #(.UART_CNT(U), .DEPTH_LOG2(DL)) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_we       (w_we),
    .w_din      (w_din),
    .w_full     (w_full),
    .w_count    (w_count),
    .w_drained  (w_drained),
    .w_overflow (w_overflow),
    .w_uart_tx  (w_uart_tx)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: FIFO contents, position in current frame (-1 = no frame), byte in flight.
  logic [7:0] m_q[$];
  int         m_f = -1;
  logic [7:0] m_cur = 8'd0;
  logic       m_ovf = 1'b0;
  logic [7:0] sent_q[$];

  // Receiver state.
  int         rx_t = -1;
  logic [7:0] rx_b = 8'd0;
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic exp_line();
    int k;
    if (m_f < 0) return 1'b1;
    k = m_f / U;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    sent_q.delete();
    rx_q.delete();
    m_f   = -1;
    m_ovf = 1'b0;
    rx_t  = -1;
  endtask

  task automatic model_update(input logic we, input logic [7:0] din);
    int pre_size;
    logic acc;
    if (!w_rst_n) begin
      model_reset();
      return;
    end
    pre_size = m_q.size();
    acc = we && (pre_size < D);
    if (we && !acc) m_ovf = 1'b1;
    if (m_f >= 0) begin
      m_f++;
      if (m_f == FRAME) m_f = -1;
    end
    if (m_f < 0 && m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      m_f = 0;
    end
    if (acc) begin
      m_q.push_back(din);
      sent_q.push_back(din);
    end
    if (we) $display("push 0x%02h %s (fifo=%0d)", din, acc ? "accepted" : "dropped", m_q.size());
  endtask

  task automatic rx_sample();
    int k;
    if (!w_rst_n) return;
    if (rx_t < 0 && w_uart_tx == 1'b0) rx_t = 0;
    if (rx_t >= 0) begin
      if (rx_t % U == U / 2) begin
        k = rx_t / U;
        if (k >= 1 && k <= 8) rx_b[k-1] = w_uart_tx;
        else if (k == 9) begin
          rx_q.push_back(rx_b);
          rx_t = -2;
        end
      end
      rx_t++;
    end
  endtask

  task automatic check_all();
    check("line",     int'(w_uart_tx),  int'(exp_line()));
    check("count",    int'(w_count),    m_q.size());
    check("full",     int'(w_full),     int'(m_q.size() == D));
    check("drained",  int'(w_drained),  int'(m_q.size() == 0 && m_f < 0));
    check("overflow", int'(w_overflow), int'(m_ovf));
    rx_sample();
  endtask

  task automatic step(input logic we, input logic [7:0] din);
    w_we  = we;
    w_din = din;
    @(posedge w_clk);
    model_update(we, din);
    @(negedge w_clk);
    w_we = 1'b0;
    check_all();
  endtask

  task automatic drain();
    int guard = 0;
    while (!(m_f < 0 && m_q.size() == 0) && guard < 2000) begin
      step(1'b0, 8'd0);
      guard++;
    end
    check("drain_timeout", int'(guard < 2000), 1);
    step(1'b0, 8'd0);
    check("rx_len", rx_q.size(), sent_q.size());
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
      check("rx_byte", int'(rx_q[i]), int'(sent_q[i]));
    rx_q.delete();
    sent_q.delete();
  endtask

  task automatic wait_stop_end();
    int guard = 0;
    while (m_f != FRAME - 1 && guard < 1000) begin
      step(1'b0, 8'd0);
      guard++;
    end
    check("stop_wait_timeout", int'(guard < 1000), 1);
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    model_reset();
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    w_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int guard;
    // Reset state
    @(negedge w_clk);
    check_all();
    @(negedge w_clk);
    w_rst_n = 1'b1;

    // 1: single frame of 0x41, drained returns at cycle 42
    step(1'b1, 8'h41);
    n = 1;
    while (!w_drained && n < 100) begin
      step(1'b0, 8'd0);
      n++;
    end
    check("t1_drain_cycle", n, 42);
    drain();

    // 2: two back-to-back frames
    step(1'b1, 8'h55);
    step(1'b1, 8'hAA);
    drain();

    // 3: six consecutive pushes, sixth dropped
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
    check("t3_ovf", int'(w_overflow), 1);
    check("t3_full", int'(w_full), 1);
    drain();
    do_reset();

    // 4: reset during DATA bit 3 of 0x0F
    step(1'b1, 8'h0F);
    step(1'b1, 8'h33);
    guard = 0;
    while (m_f < 4 * U + 1 && guard < 100) begin
      step(1'b0, 8'd0);
      guard++;
    end
    w_rst_n = 1'b0;
    #1;
    check("t4_line", int'(w_uart_tx), 1);
    check("t4_count", int'(w_count), 0);
    check("t4_drained", int'(w_drained), 1);
    model_reset();
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    w_rst_n = 1'b1;
    step(1'b1, 8'h01);
    drain();

    // 5: push while full in the cycle STOP pops
    step(1'b1, 8'h11);
    step(1'b0, 8'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom));
    wait_stop_end();
    step(1'b1, 8'h99);
    check("t5_ovf", int'(w_overflow), 1);
    check("t5_count", int'(w_count), 3);
    drain();
    do_reset();

    // 6: push during a pop with count=2
    step(1'b1, 8'h21);
    step(1'b0, 8'd0);
    step(1'b1, 8'h22);
    step(1'b1, 8'h23);
    wait_stop_end();
    step(1'b1, 8'h24);
    check("t6_count", int'(w_count), 2);
    drain();

    // 7: 20 random characters, paced so the FIFO never overflows
    for (int i = 0; i < 20; i++) begin
      guard = 0;
      while (m_q.size() >= D - 1 && guard < 200) begin
        step(1'b0, 8'd0);
        guard++;
      end
      step(1'b1, 8'($urandom));
      repeat ($urandom_range(0, 30)) step(1'b0, 8'd0);
    end
    drain();
    check("t7_ovf", int'(w_overflow), 0);

    // Random soak including overflow
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 2) == 0), 8'($urandom));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
